// File: rtl/coherence_ctrl_if.sv
// Bus bundle between the two-core coherence controller, the L1 caches and the RAM.
// The controller connects through the slave modport; the cache/RAM side uses master.
interface coherence_ctrl_if;
  // dcache side
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       cctrans;
  logic [1:0]       ccwrite;
  logic [1:0]       dwait;
  logic [1:0][31:0] dload;
  logic [1:0]       ccwait;
  logic [1:0]       ccinv;
  logic [1:0][31:0] ccsnoopaddr;

  // icache side
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;

  // RAM side
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  logic [1:0]       ramstate;

  modport slave (
    input  dREN, dWEN, daddr, dstore, cctrans, ccwrite,
    input  iREN, iaddr,
    input  ramload, ramstate,
    output dwait, dload, ccwait, ccinv, ccsnoopaddr,
    output iwait, iload,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output dREN, dWEN, daddr, dstore, cctrans, ccwrite,
    output iREN, iaddr,
    output ramload, ramstate,
    input  dwait, dload, ccwait, ccinv, ccsnoopaddr,
    input  iwait, iload,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_ctrl.sv
// Two-core snooping coherence controller: arbitrates writebacks, snoops,
// cache-to-cache transfers, RAM block reads and instruction fetches onto one RAM port.
module coherence_ctrl #(
  parameter int CPUS = 2
) (
  input logic             CLK,
  input logic             nRST,
  coherence_ctrl_if.slave ccif
);

  typedef enum logic [2:0] {
    IDLE,
    WB,
    SNOOP,
    C2C,
    RAMRD,
    IFETCH
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t          state, next_state;
  logic            core, next_core;
  logic            other;
  logic            rr;
  logic [31:0]     snoop_addr, next_snoop_addr;
  logic            snoop_inv, next_snoop_inv;
  logic [CPUS-1:0] wb_req;
  logic            access;
  logic            resp;
  logic            resp_dirty;
  logic            fwd_hit;

  // Single requester wins outright; a two-way tie goes to the round-robin pointer.
  function automatic logic pick(input logic [1:0] req, input logic ptr);
    return (&req) ? ptr : req[1];
  endfunction

  assign other  = ~core;
  assign access = (ccif.ramstate == RAM_ACCESS);
  assign wb_req = ccif.dWEN & ~ccif.cctrans;

  // A snoopee that is itself busy with a request answers as clean, so two
  // cores snooping each other cannot deadlock.
  assign resp       = ccif.cctrans[other];
  assign resp_dirty = ccif.ccwrite[other] & ~(ccif.dREN[other] | ccif.dWEN[other]);
  assign fwd_hit    = ccif.dREN[core] && (ccif.daddr[core] == ccif.daddr[other]);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      core       <= 1'b0;
      rr         <= 1'b0;
      snoop_addr <= '0;
      snoop_inv  <= 1'b0;
    end else begin
      state      <= next_state;
      core       <= next_core;
      snoop_addr <= next_snoop_addr;
      snoop_inv  <= next_snoop_inv;
      if ((state != IDLE) && (next_state == IDLE)) begin
        rr <= ~rr;
      end
    end
  end

  always_comb begin
    next_state      = state;
    next_core       = core;
    next_snoop_addr = snoop_addr;
    next_snoop_inv  = snoop_inv;
    unique case (state)
      IDLE: begin
        if (|wb_req) begin
          next_state = WB;
          next_core  = pick(wb_req, rr);
        end else if (|ccif.cctrans) begin
          next_state      = SNOOP;
          next_core       = pick(ccif.cctrans, rr);
          next_snoop_addr = ccif.daddr[next_core];
          next_snoop_inv  = ccif.ccwrite[next_core];
        end else if (|ccif.iREN) begin
          next_state = IFETCH;
          next_core  = pick(ccif.iREN, rr);
        end
      end
      WB: begin
        if (!ccif.dWEN[core]) begin
          next_state = IDLE;
        end
      end
      SNOOP: begin
        if (resp) begin
          if (resp_dirty) begin
            next_state = C2C;
          end else if (ccif.dREN[core]) begin
            next_state = RAMRD;
          end else begin
            next_state = IDLE;
          end
        end
      end
      C2C: begin
        if (!ccif.dWEN[other]) begin
          next_state = ccif.dREN[core] ? RAMRD : IDLE;
        end
      end
      RAMRD: begin
        if (!ccif.dREN[core]) begin
          next_state = IDLE;
        end
      end
      IFETCH: begin
        if (access) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (next_state == IDLE) begin
      next_snoop_addr = '0;
      next_snoop_inv  = 1'b0;
    end
  end

  always_comb begin
    ccif.dwait       = '1;
    ccif.iwait       = '1;
    ccif.ccwait      = '0;
    ccif.ccinv       = '0;
    ccif.ccsnoopaddr = '0;
    ccif.dload       = '0;
    ccif.iload       = '0;
    ccif.ramREN      = 1'b0;
    ccif.ramWEN      = 1'b0;
    ccif.ramaddr     = '0;
    ccif.ramstore    = '0;

    // Snoop address and invalidate stay on the snoopee until the transaction ends.
    if (state inside {SNOOP, C2C, RAMRD}) begin
      ccif.ccsnoopaddr[other] = snoop_addr;
      ccif.ccinv[other]       = snoop_inv;
    end

    unique case (state)
      WB: begin
        if (ccif.dWEN[core]) begin
          ccif.ramWEN   = 1'b1;
          ccif.ramaddr  = ccif.daddr[core];
          ccif.ramstore = ccif.dstore[core];
          if (access) begin
            ccif.dwait[core] = 1'b0;
          end
        end
      end
      SNOOP: begin
        ccif.ccwait[other] = 1'b1;
      end
      C2C: begin
        if (ccif.dWEN[other]) begin
          ccif.ramWEN   = 1'b1;
          ccif.ramaddr  = ccif.daddr[other];
          ccif.ramstore = ccif.dstore[other];
          if (access) begin
            ccif.dwait[other] = 1'b0;
            if (fwd_hit) begin
              ccif.dload[core] = ccif.dstore[other];
              ccif.dwait[core] = 1'b0;
            end
          end
        end
      end
      RAMRD: begin
        if (ccif.dREN[core]) begin
          ccif.ramREN  = 1'b1;
          ccif.ramaddr = ccif.daddr[core];
          if (access) begin
            ccif.dload[core] = ccif.ramload;
            ccif.dwait[core] = 1'b0;
          end
        end
      end
      IFETCH: begin
        ccif.ramREN  = 1'b1;
        ccif.ramaddr = ccif.iaddr[core];
        if (access) begin
          ccif.iload[core] = ccif.ramload;
          ccif.iwait[core] = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule
